// File: rtl/linear_seg_acc.sv
// rtl/linear_seg_acc.sv - segmented int8 dot-product accumulator with bias row and int16/clipped-ReLU output
// Optional LINEAR_SEG_ACC_CRELU_EN: clamp outputs to 0..127 instead of int16 saturation.
module linear_seg_acc #(
  parameter int IN    = 64,
  parameter int OUT   = 16,
  parameter int SEG   = 16,
  parameter int SHIFT = 0,
  localparam int NSEG = IN / SEG,
  localparam int AW   = $clog2(NSEG + 1)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [IN*8-1:0]       x,
  output logic                  mem_req,
  output logic [AW-1:0]         mem_addr,
  input  logic                  mem_valid,
  input  logic [SEG*OUT*8-1:0]  mem_w,
  input  logic [OUT*16-1:0]     mem_b,
  output logic                  busy,
  output logic                  done,
  output logic [OUT*16-1:0]     y
);

  typedef enum logic [1:0] {IDLE, BIAS, ACC, DONE} state_t;

  state_t             state, state_nx;
  logic               pend;
  logic               rsp;
  logic               last;
  logic               issue;
  logic signed [31:0] acc    [OUT];
  logic signed [31:0] acc_nx [OUT];
  logic [OUT*16-1:0]  y_nx;
  logic [SEG*8-1:0]   x_seg;
  int                 seg_idx;
  logic signed [15:0] xe, we, prod;
  logic signed [31:0] sum, shd;

  // Responses count only while a request of ours is in flight; this also drops
  // responses to requests issued before a reset.
  assign rsp  = mem_valid && pend;
  assign last = (mem_addr == AW'(NSEG));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    issue    = 1'b0;
    busy     = (state != IDLE);
    done     = 1'b0;
    case (state)
      IDLE: if (start) begin
        state_nx = BIAS;
        issue    = 1'b1;
      end
      BIAS: if (rsp) begin
        state_nx = ACC;
        issue    = 1'b1;
      end
      ACC: if (rsp) begin
        if (last) state_nx = DONE;
        else      issue    = 1'b1;
      end
      DONE: begin
        done     = 1'b1;
        state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_comb begin
    seg_idx = (mem_addr == '0) ? 0 : int'(mem_addr) - 1;
    x_seg   = x[seg_idx*SEG*8 +: SEG*8];
  end

  // Final-segment sum is saturated in the same cycle so y is valid with done.
  always_comb begin
    xe   = '0;
    we   = '0;
    prod = '0;
    sum  = '0;
    shd  = '0;
    y_nx = '0;
    for (int j = 0; j < OUT; j++) begin
      sum = '0;
      for (int i = 0; i < SEG; i++) begin
        xe   = {{8{x_seg[8*i+7]}}, x_seg[8*i +: 8]};
        we   = {{8{mem_w[(j*SEG+i)*8+7]}}, mem_w[(j*SEG+i)*8 +: 8]};
        prod = xe * we;
        sum  = sum + {{16{prod[15]}}, prod};
      end
      acc_nx[j] = acc[j] + sum;
      shd       = acc_nx[j] >>> SHIFT;
`ifdef LINEAR_SEG_ACC_CRELU_EN
      if (shd < 32'sd0)        y_nx[16*j +: 16] = 16'd0;
      else if (shd > 32'sd127) y_nx[16*j +: 16] = 16'd127;
      else                     y_nx[16*j +: 16] = shd[15:0];
`else
      if (shd > 32'sd32767)       y_nx[16*j +: 16] = 16'h7fff;
      else if (shd < -32'sd32768) y_nx[16*j +: 16] = 16'h8000;
      else                        y_nx[16*j +: 16] = shd[15:0];
`endif
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_req  <= 1'b0;
      mem_addr <= '0;
      pend     <= 1'b0;
      y        <= '0;
      for (int j = 0; j < OUT; j++) acc[j] <= '0;
    end else begin
      mem_req <= issue;
      if (issue)    pend <= 1'b1;
      else if (rsp) pend <= 1'b0;
      if (state == IDLE && start) mem_addr <= '0;
      else if (issue)             mem_addr <= mem_addr + AW'(1);
      if (state == BIAS && rsp) begin
        for (int j = 0; j < OUT; j++) acc[j] <= {{16{mem_b[16*j+15]}}, mem_b[16*j +: 16]};
      end
      if (state == ACC && rsp) begin
        for (int j = 0; j < OUT; j++) acc[j] <= acc_nx[j];
        if (last) y <= y_nx;
      end
    end
  end

endmodule

// File: tb/tb_linear_seg_acc.sv
// tb/tb_linear_seg_acc.sv - self-checking bench for linear_seg_acc (SHIFT=0 and SHIFT=4 instances)
module tb_linear_seg_acc;
  localparam int IN   = 64;
  localparam int OUT  = 16;
  localparam int SEG  = 16;
  localparam int NSEG = IN / SEG;
  localparam int AW   = $clog2(NSEG + 1);
  localparam int YW   = OUT * 16;

  logic              clk, rst_n, start, mem_valid;
  logic [IN*8-1:0]   x;
  logic [SEG*OUT*8-1:0] mem_w;
  logic [YW-1:0]     mem_b;
  logic              mem_req0, mem_req1, busy0, busy1, done0, done1;
  logic [AW-1:0]     mem_addr0, mem_addr1;
  logic [YW-1:0]     y0, y1;

  int checks = 0;
  int failures = 0;
  int fixed_l = 1;

  int xa [IN];
  int wa [NSEG][OUT][SEG];
  int ba [OUT];

  linear_seg_acc #(.IN(IN), .OUT(OUT), .SEG(SEG), .SHIFT(0)) dut0 (
    .clk(clk), .rst_n(rst_n), .start(start), .x(x), .mem_req(mem_req0), .mem_addr(mem_addr0),
    .mem_valid(mem_valid), .mem_w(mem_w), .mem_b(mem_b), .busy(busy0), .done(done0), .y(y0));

  linear_seg_acc #(.IN(IN), .OUT(OUT), .SEG(SEG), .SHIFT(4)) dut1 (
    .clk(clk), .rst_n(rst_n), .start(start), .x(x), .mem_req(mem_req1), .mem_addr(mem_addr1),
    .mem_valid(mem_valid), .mem_w(mem_w), .mem_b(mem_b), .busy(busy1), .done(done1), .y(y1));

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string nm, input logic [YW-1:0] act, input logic [YW-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  function automatic logic [YW-1:0] model(input int sh);
    logic [YW-1:0] r;
    int a, s;
    r = '0;
    for (int j = 0; j < OUT; j++) begin
      a = ba[j];
      for (int n = 0; n < IN; n++) a += xa[n] * wa[n / SEG][j][n % SEG];
      s = a >>> sh;
`ifdef LINEAR_SEG_ACC_CRELU_EN
      if (s < 0) s = 0;
      if (s > 127) s = 127;
`else
      if (s < -32768) s = -32768;
      if (s > 32767) s = 32767;
`endif
      r[16*j +: 16] = s[15:0];
    end
    return r;
  endfunction

  function automatic logic [YW-1:0] rep(input int v);
    logic [15:0] t;
    t = v[15:0];
    return {OUT{t}};
  endfunction

  task automatic pack_x();
    int t;
    for (int n = 0; n < IN; n++) begin
      t = xa[n];
      x[8*n +: 8] = t[7:0];
    end
  endtask

  // Memory: one response per request, latency fixed_l or random 1..5 when fixed_l is 0.
  initial begin
    int row, lat, t;
    mem_valid = 1'b0;
    mem_w = '0;
    mem_b = '0;
    forever begin
      @(negedge clk);
      if (mem_req0) begin
        row = int'(mem_addr0);
        lat = (fixed_l > 0) ? fixed_l : int'($urandom_range(1, 5));
        repeat (lat) @(posedge clk);
        #1;
        mem_w = {SEG*OUT/4{$urandom()}};
        mem_b = {OUT/2{$urandom()}};
        if (row == 0) begin
          for (int j = 0; j < OUT; j++) begin
            t = ba[j];
            mem_b[16*j +: 16] = t[15:0];
          end
        end else begin
          for (int j = 0; j < OUT; j++)
            for (int i = 0; i < SEG; i++) begin
              t = wa[row-1][j][i];
              mem_w[(j*SEG+i)*8 +: 8] = t[7:0];
            end
        end
        mem_valid = 1'b1;
        @(posedge clk);
        #1 mem_valid = 1'b0;
      end
    end
  end

  task automatic run_eval(input bit poke, output int lat, output int ndone, output bit busy_seen,
                          output logic [YW-1:0] ya, output logic [YW-1:0] yb, output bit d1_ok);
    lat = -1; ndone = 0; busy_seen = 0; ya = '0; yb = '0; d1_ok = 0;
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    for (int n = 1; n <= 400; n++) begin
      @(negedge clk);
      if (n == 1) busy_seen = busy0;
      if (poke && n == 3) start = 1'b1;
      if (poke && n == 4) start = 1'b0;
      if (done0) begin
        if (lat < 0) begin
          lat = n; ya = y0; yb = y1; d1_ok = done1;
        end
        ndone++;
      end
      if (lat >= 0 && n >= lat + 6) break;
    end
  endtask

  typedef struct {int xv; int wv; int bv; int e0; int e4;} vec_t;
  vec_t tv [5];

  initial begin
    int lat, nd;
    bit bs, d1;
    logic [YW-1:0] ya, yb;
    bit saw_req, saw_busy, saw_done;
    int wait_n;

`ifdef LINEAR_SEG_ACC_CRELU_EN
    tv[0] = '{1, 1, 5, 69, 4};
    tv[1] = '{127, 127, 32767, 127, 127};
    tv[2] = '{-128, 127, 0, 0, 0};
    tv[3] = '{2, 3, 0, 127, 24};
    tv[4] = '{-1, 1, 10, 0, 0};
`else
    tv[0] = '{1, 1, 5, 69, 4};
    tv[1] = '{127, 127, 32767, 32767, 32767};
    tv[2] = '{-128, 127, 0, -32768, -32768};
    tv[3] = '{2, 3, 0, 384, 24};
    tv[4] = '{-1, 1, 10, -54, -4};
`endif

    rst_n = 1'b0; start = 1'b0; x = '0;
    for (int j = 0; j < OUT; j++) ba[j] = 0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_y", y0, '0);
    chk("reset_busy", YW'(busy0), '0);
    chk("reset_done", YW'(done0), '0);
    chk("reset_mem_req", YW'(mem_req0), '0);
    chk("reset_mem_addr", YW'(mem_addr0), '0);
    rst_n = 1'b1;

    for (int v = 0; v < 5; v++) begin
      for (int n = 0; n < IN; n++) xa[n] = tv[v].xv;
      for (int k = 0; k < NSEG; k++)
        for (int j = 0; j < OUT; j++)
          for (int i = 0; i < SEG; i++) wa[k][j][i] = tv[v].wv;
      for (int j = 0; j < OUT; j++) ba[j] = tv[v].bv;
      pack_x();
      fixed_l = 1;
      run_eval(1'b0, lat, nd, bs, ya, yb, d1);
      chk($sformatf("vec%0d_latency", v), YW'(lat), YW'(11));
      chk($sformatf("vec%0d_done_pulses", v), YW'(nd), YW'(1));
      chk($sformatf("vec%0d_busy", v), YW'(bs), YW'(1));
      chk($sformatf("vec%0d_y_shift0", v), ya, rep(tv[v].e0));
      chk($sformatf("vec%0d_y_shift4", v), yb, rep(tv[v].e4));
    end

    for (int r = 0; r < 6; r++) begin
      for (int n = 0; n < IN; n++) xa[n] = int'($urandom_range(0, 255)) - 128;
      for (int k = 0; k < NSEG; k++)
        for (int j = 0; j < OUT; j++)
          for (int i = 0; i < SEG; i++) wa[k][j][i] = int'($urandom_range(0, 255)) - 128;
      for (int j = 0; j < OUT; j++) ba[j] = int'($urandom_range(0, 65535)) - 32768;
      pack_x();
      fixed_l = (r == 0) ? 3 : 0;
      run_eval(1'b1, lat, nd, bs, ya, yb, d1);
      if (r == 0) chk("rand_latency_L3", YW'(lat), YW'(21));
      chk($sformatf("rand%0d_done_pulses", r), YW'(nd), YW'(1));
      chk($sformatf("rand%0d_done_shift4", r), YW'(d1), YW'(1));
      chk($sformatf("rand%0d_y_shift0", r), ya, model(0));
      chk($sformatf("rand%0d_y_shift4", r), yb, model(4));
    end

    // Reset while segment 2 is outstanding; its late response must be dropped.
    fixed_l = 5;
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    wait_n = 0;
    do begin
      @(negedge clk);
      wait_n++;
    end while (!(mem_req0 && mem_addr0 == AW'(3)) && wait_n < 200);
    chk("seg2_request_seen", YW'(wait_n < 200), YW'(1));
    #1 rst_n = 1'b0;
    #1;
    chk("midreset_y", y0, '0);
    chk("midreset_busy", YW'(busy0), '0);
    chk("midreset_done", YW'(done0), '0);
    chk("midreset_mem_req", YW'(mem_req0), '0);
    chk("midreset_mem_addr", YW'(mem_addr0), '0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    saw_req = 0; saw_busy = 0; saw_done = 0;
    for (int n = 0; n < 10; n++) begin
      @(negedge clk);
      saw_req  |= mem_req0;
      saw_busy |= busy0;
      saw_done |= done0;
    end
    chk("stray_valid_req", YW'(saw_req), '0);
    chk("stray_valid_busy", YW'(saw_busy), '0);
    chk("stray_valid_done", YW'(saw_done), '0);
    chk("stray_valid_y", y0, '0);

    for (int n = 0; n < IN; n++) xa[n] = int'($urandom_range(0, 255)) - 128;
    for (int k = 0; k < NSEG; k++)
      for (int j = 0; j < OUT; j++)
        for (int i = 0; i < SEG; i++) wa[k][j][i] = int'($urandom_range(0, 255)) - 128;
    for (int j = 0; j < OUT; j++) ba[j] = int'($urandom_range(0, 65535)) - 32768;
    pack_x();
    fixed_l = 0;
    run_eval(1'b0, lat, nd, bs, ya, yb, d1);
    chk("post_reset_done_pulses", YW'(nd), YW'(1));
    chk("post_reset_y_shift0", ya, model(0));
    chk("post_reset_y_shift4", yb, model(4));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end
endmodule

// File: doc/linear_seg_acc.md
LINEAR_SEG_ACC -- requirements
Module: linear_seg_acc

Interface
REQ-001 Parameter IN, default 64: number of signed 8-bit inputs; SHALL be a multiple of SEG.
REQ-002 Parameter OUT, default 16: number of output channels.
REQ-003 Parameter SEG, default 16: inputs consumed per weight row (segment); NSEG = IN/SEG.
REQ-004 Parameter SHIFT, default 0: arithmetic right shift applied to the accumulator before output saturation; range 0..15.
REQ-005 clk  in  1  sole clock; all state on rising edge.
REQ-006 rst_n  in  1  reset, asynchronous and active-low.
REQ-007 start  in  1  one-cycle request to begin an evaluation; sampled only in IDLE.
REQ-008 x  in  IN*8  signed inputs; x[i] at bits [8i+7:8i]; SHALL be held stable from start until done.
REQ-009 mem_req  out  1  one-cycle read request to weight/bias memory.
REQ-010 mem_addr  out  clog2(NSEG+1)  row address: 0 = bias row, k+1 = weight segment k.
REQ-011 mem_valid  in  1  one-cycle response strobe for the outstanding request; arbitrary latency >= 1.
REQ-012 mem_w  in  SEG*OUT*8  signed weights; w[j][i] (output j, input i of segment) at byte j*SEG+i.
REQ-013 mem_b  in  OUT*16  signed biases; b[j] at bits [16j+15:16j]; valid with mem_valid on row 0.
REQ-014 busy  out  1  high from the cycle after accepted start until done.
REQ-015 done  out  1  one-cycle pulse when out is updated.
REQ-016 y  out  OUT*16  signed results; y[j] at bits [16j+15:16j]; held until next done.

Function
REQ-017 FSM states IDLE, BIAS, ACC, DONE; IDLE -> BIAS on start.
REQ-018 BIAS: issue mem_req with mem_addr=0 on entry; on mem_valid load acc[j] = sign-extend(b[j]); go to ACC.
REQ-019 ACC: issue mem_req for row k+1 (k = 0..NSEG-1); on mem_valid add sum over i of x[k*SEG+i]*w[j][i] to acc[j]; k increments; after k=NSEG-1 go to DONE.
REQ-020 At most one request outstanding; next mem_req SHALL issue in the cycle after mem_valid (no bubbles beyond one cycle per segment).
REQ-021 Accumulators SHALL be 32-bit signed; products 16-bit signed; no overflow for IN <= 65536.
REQ-022 DONE: y[j] = saturate_int16(acc[j] >>> SHIFT); done=1 for one cycle; return to IDLE.
REQ-023 Latency with mem_valid latency L: done asserts (NSEG+1)*(L+1)+1 cycles after start.
REQ-024 start while busy or in DONE SHALL be ignored; mem_valid while no request outstanding SHALL be ignored.
REQ-025 NSEG=1 SHALL take exactly one ACC segment; no special case.

Reset
REQ-026 rst_n low (any state, including mid-evaluation) SHALL force IDLE, mem_req=0, mem_addr=0, busy=0, done=0, y=0, acc=0.
REQ-027 A mem_valid arriving after reset for a pre-reset request SHALL be ignored.

Configuration
REQ-028 Macro LINEAR_SEG_ACC_CRELU_EN defined: in DONE, y[j] = clamp(acc[j] >>> SHIFT, 0, 127) (clipped ReLU, NNUE-style); undefined: plain int16 saturation per REQ-022.

Verification
REQ-029 IN=64,SEG=16, x all 1, all weights 1, bias 5, L=1, SHIFT=0 -> y[j]=69, done at cycle 11 after start.
REQ-030 x all 127, weights all 127, bias 32767, SHIFT=0 -> y[j]=32767 (saturation); with CRELU_EN -> 127.
REQ-031 x all -128, weights all 127, bias 0 -> y[j]=-32768; with CRELU_EN -> 0.
REQ-032 SHIFT=4, x=2, w=3, bias 0, IN=64 -> acc 384, y[j]=24.
REQ-033 Random L in 1..5 per request, second start pulsed while busy -> single done, results match golden model, start ignored.
REQ-034 rst_n low during ACC segment 2, stray mem_valid afterwards -> all outputs 0, FSM IDLE, next start evaluates correctly.
